// File: rtl/rv32i_packet.sv
// Pipeline packet passed from fetch to decode. Fetch drives valid, pc and
// instruction only; the decoded fields are filled in by later stages.
package rv32i_packet;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [6:0]  opcode;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] imm;
    } rv32i_data_t;

    typedef struct packed {
        logic        valid;
        rv32i_data_t data;
    } rv32i_packet_t;

endpackage

// File: rtl/rv32i_types.sv
// Shared fetch-side types: FSM encoding and the fetch buffer entry.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry skid FIFO holding fetched words; head drives the decode packet.
module fetch_buffer
    import rv32i_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic         head_valid_o,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    logic         head_valid_q, head_valid_d;
    logic         skid_valid_q, skid_valid_d;
    fetch_entry_t head_q, head_d;
    fetch_entry_t skid_q, skid_d;

    always_comb begin
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        head_d       = head_q;
        skid_d       = skid_q;
        if (flush_i) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            // Shift first so a push in the same cycle lands behind the old skid word.
            if (pop_i && head_valid_q) begin
                head_valid_d = skid_valid_q;
                head_d       = skid_q;
                skid_valid_d = 1'b0;
            end
            if (push_i) begin
                if (!head_valid_d) begin
                    head_valid_d = 1'b1;
                    head_d       = push_data_i;
                end else if (!skid_valid_d) begin
                    skid_valid_d = 1'b1;
                    skid_d       = push_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            head_q       <= '0;
            skid_q       <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
        end
    end

    assign head_valid_o = head_valid_q;
    assign head_o       = head_q;
    assign count_o      = {1'b0, head_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/if_stage.sv
// RV32I instruction fetch: owns the PC, issues one imem read at a time,
// predicts pc+4 and restarts at redirect_pc on an execute-stage redirect.
module if_stage
    import rv32i_packet::*;
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
)
(
    input  logic          clk,
    input  logic          rst,
    output logic          imem_read,
    output logic [31:0]   imem_address,
    input  logic [31:0]   imem_rdata,
    input  logic          imem_resp,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output rv32i_packet_t if_out
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;

    logic         buf_push, buf_pop, buf_flush;
    fetch_entry_t buf_push_data;
    logic         head_valid;
    fetch_entry_t head;
    logic [1:0]   count, count_next;

    assign buf_flush     = redirect;
    assign buf_pop       = head_valid & ~stall;
    assign buf_push      = (state_q == BUSY) & imem_resp & ~redirect;
    assign buf_push_data = '{pc: pc_q, instruction: imem_rdata};
    assign count_next    = buf_flush ? 2'd0
                                     : count + {1'b0, buf_push} - {1'b0, buf_pop};

    fetch_buffer u_buf (
        .clk          (clk),
        .rst          (rst),
        .push_i       (buf_push),
        .push_data_i  (buf_push_data),
        .pop_i        (buf_pop),
        .flush_i      (buf_flush),
        .head_valid_o (head_valid),
        .head_o       (head),
        .count_o      (count)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        if (redirect) begin
            pc_d = redirect_pc;
            // An unanswered request must complete at its stale address before the new one starts.
            if (state_q == IDLE || imem_resp) begin
                state_d    = BUSY;
                req_addr_d = redirect_pc;
            end else begin
                state_d = FLUSH;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (count_next < 2'd2) begin
                        state_d    = BUSY;
                        req_addr_d = pc_q;
                    end
                end
                BUSY: begin
                    if (imem_resp) begin
                        pc_d = pc_q + INSTR_BYTES;
                        if (count_next < 2'd2) begin
                            req_addr_d = pc_q + INSTR_BYTES;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (imem_resp) begin
                        state_d    = BUSY;
                        req_addr_d = pc_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign imem_read    = (state_q != IDLE);
    assign imem_address = req_addr_q;

    always_comb begin
        if_out                  = '0;
        if_out.valid            = head_valid;
        if_out.data.pc          = head.pc;
        if_out.data.instruction = head.instruction;
    end

endmodule
